// File: rtl/sdft_scheduler.sv
// Arbitrates one shared sDFT engine between sample updates and bin readouts; samples pre-empt reads between bins.
// sdft_start follows the sample strobe by one cycle when idle, a bin costs 5 cycles; sdft_ready gates every command, a full buffer drops and flags overrun.
module sdft_scheduler #(
    parameter int  freq_bins  = 320,
    parameter int  data_width = 8,
    parameter int  freq_w     = 20,
    parameter int  mag_shift  = 4,
    localparam int bin_addr_w = $clog2(freq_bins)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [data_width-1:0]    sample_in,
    input  logic                     sample_valid,
    input  logic                     line_req,
    output logic [data_width-1:0]    sdft_sample,
    output logic                     sdft_start,
    output logic                     sdft_read,
    output logic [bin_addr_w-1:0]    sdft_bin_addr,
    input  logic                     sdft_ready,
    input  logic signed [freq_w-1:0] sdft_real,
    input  logic signed [freq_w-1:0] sdft_imag,
    output logic                     bin_valid,
    output logic [bin_addr_w-1:0]    bin_index,
    output logic [7:0]               bin_mag,
    output logic                     line_done,
    output logic                     busy,
    output logic                     overrun
);

    typedef enum logic [2:0] {IDLE, START, WAIT_S, READ, WAIT_R, EMIT} state_t;

    state_t                  state, state_nxt;
    logic [data_width-1:0]   sample_buf;
    logic [data_width-1:0]   sample_hold;
    logic                    pending;
    logic                    first_q;
    logic [bin_addr_w-1:0]   rd_ptr;
    logic [7:0]              mag_q;
    logic                    last_bin;

    logic [freq_w-1:0]       abs_re, abs_im;
    logic [freq_w:0]         mag_sum, mag_shr;
    logic [7:0]              mag_sat;

    assign last_bin = (rd_ptr == bin_addr_w'(freq_bins - 1));

    // The unsigned reinterpretation of the negated value gives 2^(freq_w-1) for the most negative input.
    always_comb begin
        abs_re  = sdft_real[freq_w-1] ? $unsigned(-sdft_real) : $unsigned(sdft_real);
        abs_im  = sdft_imag[freq_w-1] ? $unsigned(-sdft_imag) : $unsigned(sdft_imag);
        mag_sum = {1'b0, abs_re} + {1'b0, abs_im};
        mag_shr = mag_sum >> mag_shift;
        mag_sat = (mag_shr > (freq_w + 1)'(255)) ? 8'hFF : mag_shr[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (sdft_ready && pending) begin
                    state_nxt = START;
                end else if (sdft_ready && busy) begin
                    state_nxt = READ;
                end
            end
            START:   state_nxt = WAIT_S;
            WAIT_S:  if (!first_q && sdft_ready) state_nxt = IDLE;
            READ:    state_nxt = WAIT_R;
            WAIT_R:  if (!first_q && sdft_ready) state_nxt = EMIT;
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sdft_start    = 1'b0;
        sdft_read     = 1'b0;
        bin_valid     = 1'b0;
        bin_index     = '0;
        bin_mag       = '0;
        line_done     = 1'b0;
        sdft_bin_addr = rd_ptr;
        sdft_sample   = sample_hold;
        case (state)
            START: sdft_start = 1'b1;
            READ:  sdft_read  = 1'b1;
            EMIT: begin
                bin_valid = 1'b1;
                bin_index = rd_ptr;
                bin_mag   = mag_q;
                line_done = last_bin;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_buf  <= '0;
            sample_hold <= '0;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            first_q     <= 1'b0;
            rd_ptr      <= '0;
            busy        <= 1'b0;
            mag_q       <= '0;
        end else begin
            first_q <= (state == START) || (state == READ);

            // START frees the buffer this cycle, so a strobe landing here is not an overrun.
            if (sample_valid) begin
                if (!pending || state == START) begin
                    sample_buf <= sample_in;
                    pending    <= 1'b1;
                end else begin
                    overrun    <= 1'b1;
                end
            end else if (state == START) begin
                pending <= 1'b0;
            end

            if (state == IDLE && state_nxt == START) begin
                sample_hold <= sample_buf;
            end

            if (state == WAIT_R && state_nxt == EMIT) begin
                mag_q <= mag_sat;
            end

            if (state == EMIT) begin
                if (last_bin) begin
                    rd_ptr <= '0;
                    busy   <= 1'b0;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end else if (line_req && !busy) begin
                busy   <= 1'b1;
                rd_ptr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sdft_scheduler.sv
// Bench for sdft_scheduler: behavioural sDFT with configurable ready latency, ordered sample/bin scoreboard.
module tb_sdft_scheduler;

    localparam int NB = 320;
    localparam int AW = $clog2(NB);

    logic              clk          = 1'b0;
    logic              reset_n      = 1'b0;
    logic [7:0]        sample_in    = '0;
    logic              sample_valid = 1'b0;
    logic              line_req     = 1'b0;
    logic [7:0]        sdft_sample;
    logic              sdft_start;
    logic              sdft_read;
    logic [AW-1:0]     sdft_bin_addr;
    logic              sdft_ready;
    logic signed [19:0] sdft_real   = '0;
    logic signed [19:0] sdft_imag   = '0;
    logic              bin_valid;
    logic [AW-1:0]     bin_index;
    logic [7:0]        bin_mag;
    logic              line_done;
    logic              busy;
    logic              overrun;

    sdft_scheduler dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .line_req     (line_req),
        .sdft_sample  (sdft_sample),
        .sdft_start   (sdft_start),
        .sdft_read    (sdft_read),
        .sdft_bin_addr(sdft_bin_addr),
        .sdft_ready   (sdft_ready),
        .sdft_real    (sdft_real),
        .sdft_imag    (sdft_imag),
        .bin_valid    (bin_valid),
        .bin_index    (bin_index),
        .bin_mag      (bin_mag),
        .line_done    (line_done),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Magnitude rule: (|re| + |im|) / 2^mag_shift, clipped to 255.
    function automatic int ref_mag(input int re, input int im);
        longint a, b, s;
        a = (re < 0) ? -longint'(re) : longint'(re);
        b = (im < 0) ? -longint'(im) : longint'(im);
        s = (a + b) / 16;
        return (s > 255) ? 255 : int'(s);
    endfunction

    function automatic int rnd_comp();
        if ($urandom_range(1, 0) == 1) return int'($urandom_range(1048575, 0)) - 524288;
        return int'($urandom_range(8000, 0)) - 4000;
    endfunction

    // sDFT model state and scoreboard
    int         mem_re[NB];
    int         mem_im[NB];
    int         obs_mag[NB];
    logic       mdl_rdy   = 1'b1;
    int         mdl_cnt   = 0;
    int         lat_mode  = 1;
    logic       stall     = 1'b0;
    logic [7:0] exp_q[$];
    int         exp_idx   = 0;
    int         start_cnt = 0;
    int         read_cnt  = 0;
    int         bv_cnt    = 0;
    int         ld_cnt    = 0;
    logic       upd_on    = 1'b0;
    logic [7:0] hold_val  = '0;
    logic       thr_on    = 1'b0;
    logic       have_last = 1'b0;
    int         last_bv   = 0;
    logic       bf_chk    = 1'b0;

    assign sdft_ready = mdl_rdy & ~stall;

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_idx   = 0;
            upd_on    = 1'b0;
            have_last = 1'b0;
            bf_chk    = 1'b0;
        end else begin
            if (bf_chk) check("busy_after_last_bin", busy, 0);
            bf_chk = 1'b0;
            if (upd_on && !mdl_rdy) check("sample_hold", sdft_sample, hold_val);
            if (upd_on && mdl_rdy) upd_on = 1'b0;
            if (sdft_start || sdft_read) check("cmd_exclusive", sdft_start & sdft_read, 0);
            if (sdft_start) begin
                start_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_without_sample: sample %0d issued, none expected (t=%0t)", sdft_sample, $time);
                end else begin
                    check("start_sample", sdft_sample, exp_q.pop_front());
                end
                hold_val = sdft_sample;
                upd_on   = 1'b1;
            end
            if (sdft_read) begin
                read_cnt++;
                sdft_real = 20'(mem_re[sdft_bin_addr]);
                sdft_imag = 20'(mem_im[sdft_bin_addr]);
            end
            // ready stays low for lat sampled wait cycles after the command cycle
            if (sdft_start || sdft_read) begin
                mdl_rdy = 1'b0;
                mdl_cnt = ((lat_mode < 0) ? int'($urandom_range(2, 0)) : lat_mode) + 1;
            end else if (!mdl_rdy) begin
                mdl_cnt--;
                if (mdl_cnt <= 0) mdl_rdy = 1'b1;
            end
            if (bin_valid) begin
                bv_cnt++;
                check("bin_index", bin_index, exp_idx);
                check("bin_mag", bin_mag, ref_mag(mem_re[exp_idx], mem_im[exp_idx]));
                check("line_done", line_done, exp_idx == NB - 1);
                obs_mag[exp_idx] = bin_mag;
                if (thr_on && have_last) check("bin_interval", cyc - last_bv, 5);
                have_last = 1'b1;
                last_bv   = cyc;
                if (line_done) ld_cnt++;
                if (exp_idx == NB - 1) bf_chk = 1'b1;
                exp_idx = (exp_idx + 1) % NB;
            end else if (line_done) begin
                check("line_done_without_valid", line_done, 0);
            end
            if (!thr_on) have_last = 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [7:0] v, input bit accept);
        sample_in    = v;
        sample_valid = 1'b1;
        if (accept) exp_q.push_back(v);
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic pulse_line();
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0 || !mdl_rdy) && n < budget) begin
            tick();
            n++;
        end
        repeat (4) tick();
        check(name, n < budget, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_sdft_start"}, sdft_start, 0);
        check({tag, "_sdft_read"}, sdft_read, 0);
        check({tag, "_sdft_bin_addr"}, sdft_bin_addr, 0);
        check({tag, "_sdft_sample"}, sdft_sample, 0);
        check({tag, "_bin_valid"}, bin_valid, 0);
        check({tag, "_bin_index"}, bin_index, 0);
        check({tag, "_bin_mag"}, bin_mag, 0);
        check({tag, "_line_done"}, line_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
    endtask

    typedef struct {
        int re;
        int im;
        int mag;
    } vec_t;

    initial begin
        vec_t tbl[14];
        int   s0, r0, b0, l0, n;

        tbl[0]  = '{-524288, 0, 255};
        tbl[1]  = '{100, -60, 10};
        tbl[2]  = '{0, 0, 0};
        tbl[3]  = '{15, 0, 0};
        tbl[4]  = '{16, 0, 1};
        tbl[5]  = '{-16, -16, 2};
        tbl[6]  = '{524287, 524287, 255};
        tbl[7]  = '{4080, 0, 255};
        tbl[8]  = '{4095, 0, 255};
        tbl[9]  = '{4096, 0, 255};
        tbl[10] = '{-4079, 0, 254};
        tbl[11] = '{-524288, -524288, 255};
        tbl[12] = '{2000, -2000, 250};
        tbl[13] = '{-1, -15, 1};

        reset_n = 1'b0;
        repeat (3) tick();
        check_zero("por");
        reset_n = 1'b1;
        repeat (2) tick();

        // single sample, engine idle
        lat_mode = 3;
        s0 = start_cnt;
        r0 = read_cnt;
        send_sample(8'h5A, 1);
        wait_idle("single_idle", 60);
        check("single_starts", start_cnt - s0, 1);
        check("single_reads", read_cnt - r0, 0);
        check("single_overrun", overrun, 0);

        // full line with table bins, fixed latency for throughput
        for (int i = 0; i < NB; i++) begin
            mem_re[i] = rnd_comp();
            mem_im[i] = rnd_comp();
        end
        for (int i = 0; i < 14; i++) begin
            mem_re[i] = tbl[i].re;
            mem_im[i] = tbl[i].im;
        end
        lat_mode = 1;
        thr_on   = 1'b1;
        b0 = bv_cnt;
        l0 = ld_cnt;
        pulse_line();
        check("line_busy_set", busy, 1);
        wait_idle("line_idle", 2500);
        thr_on = 1'b0;
        check("line_bins", bv_cnt - b0, NB);
        check("line_done_count", ld_cnt - l0, 1);
        for (int i = 0; i < 14; i++) check($sformatf("tbl_mag_%0d", i), obs_mag[i], tbl[i].mag);

        // samples every 7 cycles during a line, stray line_req ignored
        b0 = bv_cnt;
        pulse_line();
        n = 0;
        while (busy && n < 4000) begin
            if (n % 7 == 0) send_sample(8'($urandom), 1);
            else if (n % 53 == 0 && exp_idx < NB - 10) pulse_line();
            else tick();
            n++;
        end
        wait_idle("interleave_idle", 100);
        check("interleave_bins", bv_cnt - b0, NB);
        check("interleave_queue", exp_q.size(), 0);
        check("interleave_overrun", overrun, 0);

        // random latency, random gaps, random data
        for (int i = 0; i < NB; i++) begin
            mem_re[i] = rnd_comp();
            mem_im[i] = rnd_comp();
        end
        lat_mode = -1;
        b0 = bv_cnt;
        for (int ln = 0; ln < 2; ln++) begin
            pulse_line();
            n = 0;
            while (busy && n < 4000) begin
                repeat ($urandom_range(24, 11)) begin
                    if ($urandom_range(40, 0) == 0 && exp_idx < NB - 10 && busy) pulse_line();
                    else tick();
                    n++;
                end
                if (busy) send_sample(8'($urandom), 1);
                n++;
            end
            wait_idle("random_idle", 200);
        end
        check("random_bins", bv_cnt - b0, 2 * NB);
        check("random_queue", exp_q.size(), 0);
        check("random_overrun", overrun, 0);

        // strobe in the START cycle is accepted
        lat_mode = 1;
        s0 = start_cnt;
        send_sample(8'h11, 1);
        n = 0;
        while (!sdft_start && n < 10) begin
            tick();
            n++;
        end
        check("start_seen", sdft_start, 1);
        send_sample(8'h22, 1);
        wait_idle("start_strobe_idle", 60);
        check("start_strobe_starts", start_cnt - s0, 2);
        check("start_strobe_overrun", overrun, 0);

        // two strobes while the engine is held busy
        stall = 1'b1;
        s0 = start_cnt;
        tick();
        send_sample(8'hA1, 1);
        tick();
        send_sample(8'hB2, 0);
        repeat (3) tick();
        check("ovr_flag", overrun, 1);
        check("ovr_no_start", start_cnt - s0, 0);
        stall = 1'b0;
        wait_idle("ovr_idle", 60);
        check("ovr_starts", start_cnt - s0, 1);
        check("ovr_sticky", overrun, 1);

        // reset in the middle of WAIT_R with the engine left busy
        lat_mode = 3;
        pulse_line();
        n = 0;
        while (!sdft_read && n < 20) begin
            tick();
            n++;
        end
        check("rst_read_seen", sdft_read, 1);
        tick();
        check("rst_pre_overrun", overrun, 1);
        stall = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("rst");
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        s0 = start_cnt;
        r0 = read_cnt;
        send_sample(8'h3C, 1);
        repeat (8) tick();
        check("rst_hold_starts", start_cnt - s0, 0);
        check("rst_hold_reads", read_cnt - r0, 0);
        check("rst_hold_busy", busy, 0);
        stall    = 1'b0;
        lat_mode = 1;
        wait_idle("rst_sample_idle", 60);
        check("rst_sample_starts", start_cnt - s0, 1);
        b0 = bv_cnt;
        pulse_line();
        wait_idle("rst_line_idle", 2500);
        check("rst_line_bins", bv_cnt - b0, NB);
        check("rst_overrun_clear", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sdft_scheduler.md
SDFT_SCHEDULER -- requirements
Module: sdft_scheduler

Interface
REQ-001 SHALL have parameter freq_bins, default 320, the sDFT bin count and the line length.
REQ-002 SHALL have parameter data_width, default 8, the sample width.
REQ-003 SHALL have parameter freq_w, default 20, the bin component width.
REQ-004 SHALL have parameter mag_shift, default 4, the right shift applied before magnitude saturation.
REQ-005 SHALL derive bin_addr_w = $clog2(freq_bins) for every bin address and index.
REQ-006 SHALL have clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-007 SHALL have reset_n, input, 1, reset that is asynchronous and active-low.
REQ-008 SHALL have sample_in, input, data_width, the ADC sample.
REQ-009 SHALL have sample_valid, input, 1, a one-cycle strobe that qualifies sample_in.
REQ-010 SHALL have line_req, input, 1, a one-cycle strobe requesting a full bin readout.
REQ-011 SHALL have sdft_sample, output, data_width, the sample driven to the sDFT.
REQ-012 SHALL have sdft_start, output, 1, the sDFT update command.
REQ-013 SHALL have sdft_read, output, 1, the sDFT read command.
REQ-014 SHALL have sdft_bin_addr, output, bin_addr_w, the read address.
REQ-015 SHALL have sdft_ready, input, 1, high only when the sDFT is idle.
REQ-016 SHALL have sdft_real and sdft_imag, input, signed freq_w each, the bin read result.
REQ-017 SHALL have bin_valid, output, 1, a one-cycle strobe qualifying bin_index and bin_mag.
REQ-018 SHALL have bin_index, output, bin_addr_w, the bin number.
REQ-019 SHALL have bin_mag, output, 8, the saturated magnitude.
REQ-020 SHALL have line_done, output, 1, high together with bin_valid for the last bin only.
REQ-021 SHALL have busy, output, 1, high while a line readout is active.
REQ-022 SHALL have overrun, output, 1, a sticky flag set when a sample is lost.

Function
REQ-023 SHALL hold a 1-deep sample buffer; sample_valid SHALL write it and set pending.
REQ-024 If sample_valid arrives while pending=1 and the buffer is not being consumed that cycle, the new sample SHALL be dropped, the buffer SHALL keep the old sample, and overrun SHALL set.
REQ-025 If sample_valid arrives in the cycle the buffer is consumed, the new sample SHALL be accepted with no overrun.
REQ-026 States: IDLE, START, WAIT_S, READ, WAIT_R, EMIT.
REQ-027 IDLE: with sdft_ready=1 and pending=1, go to START; otherwise with sdft_ready=1 and busy=1, go to READ; otherwise stay in IDLE. Samples SHALL have priority over reads.
REQ-028 START: sdft_start=1 for exactly this cycle; the buffer SHALL be consumed (pending cleared); go to WAIT_S.
REQ-029 WAIT_S: ignore sdft_ready in the first cycle; afterwards return to IDLE when sdft_ready=1.
REQ-030 sdft_sample SHALL be held constant from START until the return to IDLE.
REQ-031 READ: sdft_read=1 for one cycle with sdft_bin_addr=rd_ptr; go to WAIT_R.
REQ-032 WAIT_R: sdft_bin_addr SHALL be held; ignore sdft_ready in the first cycle; on sdft_ready=1, register the |re|+|im| sum and go to EMIT.
REQ-033 The magnitude path SHALL compute |re|+|im| at freq_w+1 bits.
REQ-034 abs(-2^(freq_w-1)) SHALL be 2^(freq_w-1) with no wrap.
REQ-035 The sum SHALL be shifted right by mag_shift, then saturated to 255.
REQ-036 EMIT: bin_valid=1 and bin_index=rd_ptr for one cycle.
REQ-037 In EMIT, if rd_ptr=freq_bins-1: set line_done=1, clear busy, and set rd_ptr=0; otherwise increment rd_ptr. Then go to IDLE.
REQ-038 sdft_start and sdft_read SHALL never both be high, and neither SHALL be high outside START and READ.
REQ-039 line_req with busy=0 SHALL set busy and rd_ptr=0; line_req with busy=1 SHALL be ignored.
REQ-040 A sample arriving mid-line SHALL interleave between bins; no bin SHALL be skipped or repeated.
REQ-041 Bin-to-bin throughput with no samples SHALL be one bin per 5 cycles when sdft_ready returns in the second WAIT_R cycle.

Reset
REQ-042 reset_n=0 SHALL immediately force: state IDLE, pending=0, busy=0, overrun=0, rd_ptr=0, sdft_start=0, sdft_read=0, sdft_bin_addr=0, sdft_sample=0, bin_valid=0, bin_index=0, bin_mag=0, line_done=0.
REQ-043 After reset, no command SHALL issue until sdft_ready=1, which covers an sDFT left mid-update.
REQ-044 overrun SHALL clear only on reset.

Verification
REQ-045 A single sample 0x5A with the sDFT model idle -> one sdft_start pulse with sdft_sample=0x5A held until ready rises; no sdft_read.
REQ-046 A line_req with no samples -> 320 bin_valid pulses with indexes 0..319 in order; line_done only on 319; busy falls after 319.
REQ-047 Bins re=-524288, im=0 and re=100, im=-60 -> bin_mag=255 (saturated) and 10 respectively.
REQ-048 Samples every 7 cycles during a line -> every sample issued, indexes contiguous, overrun=0.
REQ-049 Two sample_valid strobes while the sDFT is busy -> first sample kept, overrun=1; reset_n low mid-WAIT_R -> all outputs 0; the next line restarts at bin 0.
